sockit_spi_xip: RTL and testbench



---
 rtl/sockit_spi_xip_if.sv | 37 +++
 rtl/sockit_spi_xip.sv | 155 +++++++++++++++
 tb/tb_sockit_spi_xip.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sockit_spi_xip_if.sv
// Bus bundle for the XIP read sequencer: request/response, command,
// write-data and read-data streams. The master modport is the sequencer.
interface sockit_spi_xip_if #(
    parameter int unsigned ADW = 24
);
    logic           req_vld;
    logic           req_rdy;
    logic [ADW-1:0] req_adr;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [31:0]    rsp_dat;
    logic           scw_vld;
    logic           scw_rdy;
    logic           scw_sso;
    logic           scw_cke;
    logic           scw_doe;
    logic           scw_die;
    logic [1:0]     scw_iom;
    logic [13:0]    scw_cnt;
    logic           sdw_vld;
    logic           sdw_rdy;
    logic [31:0]    sdw_dat;
    logic           sdr_vld;
    logic [31:0]    sdr_dat;

    modport master (
        input  req_vld, req_adr, rsp_rdy, scw_rdy, sdw_rdy, sdr_vld, sdr_dat,
        output req_rdy, rsp_vld, rsp_dat, scw_vld, scw_sso, scw_cke, scw_doe,
        output scw_die, scw_iom, scw_cnt, sdw_vld, sdw_dat
    );

    modport slave (
        output req_vld, req_adr, rsp_rdy, scw_rdy, sdw_rdy, sdr_vld, sdr_dat,
        input  req_rdy, rsp_vld, rsp_dat, scw_vld, scw_sso, scw_cke, scw_doe,
        input  scw_die, scw_iom, scw_cnt, sdw_vld, sdw_dat
    );
endinterface

// File: rtl/sockit_spi_xip.sv
// Execute-in-place read sequencer: turns one memory read into the flash read
// sequence (opcode, address, dummy, data, deselect) on the serializer streams.
module sockit_spi_xip #(
    parameter int unsigned ADW = 24,
    parameter logic [7:0]  OPC = 8'h0B,
    parameter int unsigned DMY = 8
) (
    input  logic             spi_clk,
    input  logic             spi_rst,
    input  logic [1:0]       cfg_iom,
    input  logic [13:0]      cfg_ssh,
    sockit_spi_xip_if.master bus
);

    typedef enum logic [2:0] {StIdl, StCmd, StAdr, StDmy, StDat, StWai, StEnd} state_e;

    typedef struct packed {
        logic        sso;
        logic        cke;
        logic        doe;
        logic        die;
        logic [1:0]  iom;
        logic [13:0] cnt;
    } cmd_t;

    function automatic cmd_t ent(logic sso, logic cke, logic doe, logic die,
                                 logic [1:0] iom, logic [13:0] cnt);
        cmd_t c;
        c.sso = sso;
        c.cke = cke;
        c.doe = doe;
        c.die = die;
        c.iom = iom;
        c.cnt = cnt;
        return c;
    endfunction

    // Data phase length scales with lane count so one 32-bit word is read.
    function automatic cmd_t dat_ent(logic [1:0] iom);
        logic [13:0] cnt;
        case (iom)
            2'd3:    cnt = 14'd7;
            2'd2:    cnt = 14'd15;
            default: cnt = 14'd31;
        endcase
        return ent(1'b1, 1'b1, 1'b0, 1'b1, iom, cnt);
    endfunction

    state_e         state_q;
    logic [ADW-1:0] adr_q;
    logic           req_rdy_q;
    logic           rsp_vld_q;
    logic [31:0]    rsp_dat_q;
    logic           scw_vld_q;
    cmd_t           cmd_q;
    logic           sdw_vld_q;
    logic [31:0]    sdw_dat_q;
    logic           xfer;

    assign xfer = scw_vld_q & bus.scw_rdy;

    always_ff @(posedge spi_clk or posedge spi_rst) begin
        if (spi_rst) begin
            state_q   <= StIdl;
            adr_q     <= '0;
            req_rdy_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            scw_vld_q <= 1'b0;
            cmd_q     <= '0;
            sdw_vld_q <= 1'b0;
            sdw_dat_q <= '0;
        end else begin
            if (rsp_vld_q && bus.rsp_rdy) rsp_vld_q <= 1'b0;
            case (state_q)
                StIdl: begin
                    if (bus.req_vld && req_rdy_q) begin
                        adr_q     <= bus.req_adr;
                        req_rdy_q <= 1'b0;
                        state_q   <= StCmd;
                        scw_vld_q <= 1'b1;
                        sdw_vld_q <= 1'b1;
                        cmd_q     <= ent(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 14'd7);
                        sdw_dat_q <= {OPC, 24'h0};
                    end else begin
                        req_rdy_q <= ~(rsp_vld_q & ~bus.rsp_rdy);
                    end
                end
                StCmd: begin
                    if (xfer) begin
                        state_q   <= StAdr;
                        cmd_q     <= ent(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 14'(ADW - 1));
                        sdw_dat_q <= 32'(adr_q) << (32 - ADW);
                    end
                end
                StAdr: begin
                    if (xfer) begin
                        sdw_vld_q <= 1'b0;
                        if (DMY != 0) begin
                            state_q <= StDmy;
                            cmd_q   <= ent(1'b1, 1'b1, 1'b0, 1'b0, cfg_iom, 14'(DMY - 1));
                        end else begin
                            state_q <= StDat;
                            cmd_q   <= dat_ent(cfg_iom);
                        end
                    end
                end
                StDmy: begin
                    if (xfer) begin
                        state_q <= StDat;
                        cmd_q   <= dat_ent(cfg_iom);
                    end
                end
                StDat: begin
                    if (xfer) begin
                        state_q   <= StWai;
                        scw_vld_q <= 1'b0;
                    end
                end
                StWai: begin
                    // Capture wins over a same-cycle rsp_rdy: no older response can exist here.
                    if (bus.sdr_vld) begin
                        rsp_dat_q <= bus.sdr_dat;
                        rsp_vld_q <= 1'b1;
                        state_q   <= StEnd;
                        scw_vld_q <= 1'b1;
                        cmd_q     <= ent(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, cfg_ssh);
                    end
                end
                StEnd: begin
                    if (xfer) begin
                        state_q   <= StIdl;
                        scw_vld_q <= 1'b0;
                        req_rdy_q <= ~(rsp_vld_q & ~bus.rsp_rdy);
                    end
                end
                default: state_q <= StIdl;
            endcase
        end
    end

    assign bus.req_rdy = req_rdy_q;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_dat = rsp_dat_q;
    assign bus.scw_vld = scw_vld_q;
    assign bus.scw_sso = cmd_q.sso;
    assign bus.scw_cke = cmd_q.cke;
    assign bus.scw_doe = cmd_q.doe;
    assign bus.scw_die = cmd_q.die;
    assign bus.scw_iom = cmd_q.iom;
    assign bus.scw_cnt = cmd_q.cnt;
    assign bus.sdw_vld = sdw_vld_q;
    assign bus.sdw_dat = sdw_dat_q;

endmodule

// File: tb/tb_sockit_spi_xip.sv
// Directed bench for sockit_spi_xip: full read sequences with hand-computed
// command entries, backpressure, response stall and reset during WAI.
module tb_sockit_spi_xip;

    logic        spi_clk = 1'b0;
    logic        spi_rst = 1'b1;
    logic [1:0]  cfg_iom = 2'd0;
    logic [13:0] cfg_ssh = 14'd0;
    int          checks  = 0;
    int          errors  = 0;

    sockit_spi_xip_if #(.ADW(24)) bus ();

    sockit_spi_xip #(
        .ADW (24),
        .OPC (8'h0B),
        .DMY (8)
    ) dut (
        .spi_clk (spi_clk),
        .spi_rst (spi_rst),
        .cfg_iom (cfg_iom),
        .cfg_ssh (cfg_ssh),
        .bus     (bus)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {bus.req_rdy, bus.rsp_vld, bus.rsp_dat, bus.scw_vld, bus.scw_sso,
                bus.scw_cke, bus.scw_doe, bus.scw_die, bus.scw_iom, bus.scw_cnt,
                bus.sdw_vld, bus.sdw_dat};
    endfunction

    // Fields ordered {sso, cke, doe, die, iom[1:0], cnt[13:0]}.
    task automatic entry(input string tag, input logic [19:0] exp_cmd, input logic exp_sv,
                         input logic [31:0] exp_sd, input int stall);
        logic [31:0] m;
        m = exp_sv ? 32'hFFFF_FFFF : 32'h0;
        for (int i = 0; i <= stall; i++) begin
            check(tag, {bus.scw_vld, bus.scw_sso, bus.scw_cke, bus.scw_doe, bus.scw_die,
                        bus.scw_iom, bus.scw_cnt, bus.sdw_vld, bus.sdw_dat & m},
                       {1'b1, exp_cmd, exp_sv, exp_sd & m});
            if (i < stall) @(negedge spi_clk);
        end
        bus.scw_rdy = 1'b1;
        @(negedge spi_clk);
        bus.scw_rdy = 1'b0;
    endtask

    task automatic run_read(input logic [23:0] adr, input logic [1:0] iom,
                            input logic [13:0] ssh, input logic [13:0] dcnt,
                            input logic [31:0] dat, input int stall,
                            input logic abort_wai, input logic rdy_at_sdr);
        cfg_iom     = iom;
        cfg_ssh     = ssh;
        bus.req_adr = adr;
        bus.req_vld = 1'b1;
        check("req_rdy_acc", {95'd0, bus.req_rdy}, 96'd1);
        @(negedge spi_clk);
        bus.req_vld = 1'b0;
        entry("cmd", {4'b1110, 2'd1, 14'd7}, 1'b1, 32'h0B00_0000, stall);
        entry("adr", {4'b1110, 2'd1, 14'd23}, 1'b1, {adr, 8'h00}, stall);
        entry("dmy", {4'b1100, iom, 14'd7}, 1'b0, 32'h0, stall);
        entry("dat", {4'b1101, iom, dcnt}, 1'b0, 32'h0, stall);
        check("wai_idle", {94'd0, bus.scw_vld, bus.rsp_vld}, 96'd0);
        if (abort_wai) begin
            spi_rst = 1'b1;
            #1;
            check("rst_wai", all_outs(), 96'd0);
            @(negedge spi_clk);
            spi_rst = 1'b0;
            @(negedge spi_clk);
            check("rst_wai_rdy", {95'd0, bus.req_rdy}, 96'd1);
        end else begin
            bus.sdr_vld = 1'b1;
            bus.sdr_dat = dat;
            bus.rsp_rdy = rdy_at_sdr;
            @(negedge spi_clk);
            bus.sdr_vld = 1'b0;
            bus.rsp_rdy = 1'b0;
            check("rsp", {63'd0, bus.rsp_vld, bus.rsp_dat}, {63'd0, 1'b1, dat});
            entry("end", {4'b0000, 2'd1, ssh}, 1'b0, 32'h0, stall);
            check("end_idle", {93'd0, bus.scw_vld, bus.req_rdy, bus.rsp_vld}, 96'd1);
        end
    endtask

    task automatic take_rsp();
        bus.rsp_rdy = 1'b1;
        @(negedge spi_clk);
        bus.rsp_rdy = 1'b0;
        check("rsp_clr", {94'd0, bus.rsp_vld, bus.req_rdy}, 96'd1);
    endtask

    initial begin
        bus.req_vld = 1'b0;
        bus.req_adr = '0;
        bus.rsp_rdy = 1'b0;
        bus.scw_rdy = 1'b0;
        bus.sdw_rdy = 1'b1;
        bus.sdr_vld = 1'b0;
        bus.sdr_dat = '0;
        repeat (2) @(negedge spi_clk);
        check("reset_outs", all_outs(), 96'd0);
        spi_rst = 1'b0;
        check("rdy_at_release", {95'd0, bus.req_rdy}, 96'd0);
        @(negedge spi_clk);
        check("rdy_after_release", {95'd0, bus.req_rdy}, 96'd1);

        // Stray read data outside WAI must not create a response.
        bus.sdr_vld = 1'b1;
        bus.sdr_dat = 32'h5555_AAAA;
        @(negedge spi_clk);
        bus.sdr_vld = 1'b0;
        check("sdr_ignored", {62'd0, bus.rsp_vld, bus.req_rdy, bus.rsp_dat}, {63'd1, 32'h0});

        run_read(24'h123456, 2'd0, 14'd5, 14'd31, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        take_rsp();
        run_read(24'hABCDEF, 2'd3, 14'd2, 14'd7, 32'h0123_4567, 0, 1'b0, 1'b0);
        take_rsp();
        run_read(24'h00FF01, 2'd2, 14'h3FFF, 14'd15, 32'h8000_0001, 0, 1'b0, 1'b1);
        take_rsp();
        run_read(24'hFEDCBA, 2'd1, 14'd9, 14'd31, 32'hCAFE_F00D, 5, 1'b0, 1'b0);

        // Response held: requests must be refused until rsp_rdy.
        bus.req_vld = 1'b1;
        bus.req_adr = 24'h777777;
        for (int i = 0; i < 4; i++) begin
            @(negedge spi_clk);
            check("stall_refuse", {93'd0, bus.req_rdy, bus.scw_vld, bus.rsp_vld}, 96'd1);
        end
        bus.req_vld = 1'b0;
        check("stall_dat", {64'd0, bus.rsp_dat}, {64'd0, 32'hCAFE_F00D});
        take_rsp();

        run_read(24'h0A0B0C, 2'd0, 14'd3, 14'd31, 32'h0, 0, 1'b1, 1'b0);
        run_read(24'h314159, 2'd3, 14'd1, 14'd7, 32'h2718_2818, 0, 1'b0, 1'b0);
        take_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
